// File: rtl/gpio_uart_tx.sv
// 8N1 UART transmitter with a small byte FIFO; drives the GPIO mux UART TX source.
// The serial line and all status outputs come from flops; the line idles high.
module gpio_uart_tx #(
    parameter int unsigned CLK_DIV    = 868,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       full,
    output logic       empty,
    output logic       overflow,
    output logic       busy,
    output logic       tx_done,
    output logic       uart_TX
);

    localparam int unsigned CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned COUNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t             state;
    state_t             state_next_c;

    logic [7:0]         mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [COUNT_W-1:0] count;
    logic [COUNT_W-1:0] count_next_c;
    logic               push_c;
    logic               pop_c;

    logic [CNT_W-1:0]   baud_cnt;
    logic               baud_last_c;
    logic [2:0]         bit_idx;
    logic [7:0]         shift;

    logic               tx_bit_c;
    logic               done_c;

    // Full is the registered flag, so a write on a popping cycle is still refused.
    assign push_c      = wr_en && !full;
    assign baud_last_c = (baud_cnt == CNT_W'(CLK_DIV - 1));

    always_comb begin
        count_next_c = count;
        case ({push_c, pop_c})
            2'b10:   count_next_c = count + COUNT_W'(1);
            2'b01:   count_next_c = count - COUNT_W'(1);
            default: count_next_c = count;
        endcase
    end

    // FIFO storage carries no reset; only pointers and count define its contents.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count    <= count_next_c;
            full     <= (count_next_c == COUNT_W'(FIFO_DEPTH));
            empty    <= (count_next_c == '0);
            overflow <= overflow || (wr_en && full);
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next_c;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next_c = state;
        case (state)
            IDLE: begin
                if (!empty) begin
                    state_next_c = START;
                end
            end
            START: begin
                if (baud_last_c) begin
                    state_next_c = DATA;
                end
            end
            DATA: begin
                if (baud_last_c && (bit_idx == 3'd7)) begin
                    state_next_c = STOP;
                end
            end
            STOP: begin
                if (baud_last_c) begin
                    state_next_c = empty ? IDLE : START;
                end
            end
            default: state_next_c = IDLE;
        endcase
    end

    // FSM outputs: line level, FIFO pop and end-of-frame strobe
    always_comb begin
        pop_c    = 1'b0;
        tx_bit_c = 1'b1;
        done_c   = 1'b0;
        case (state)
            IDLE: begin
                pop_c = !empty;
            end
            START: begin
                tx_bit_c = 1'b0;
            end
            DATA: begin
                tx_bit_c = shift[0];
            end
            STOP: begin
                done_c = baud_last_c;
                pop_c  = baud_last_c && !empty;
            end
            default: begin
                tx_bit_c = 1'b1;
            end
        endcase
    end

    // Baud counter, bit index and shift register; a pop always starts a fresh frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
        end else if (pop_c) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= mem[rd_ptr];
        end else if (state != IDLE) begin
            if (baud_last_c) begin
                baud_cnt <= '0;
                if (state == DATA) begin
                    shift   <= {1'b0, shift[7:1]};
                    bit_idx <= bit_idx + 3'd1;
                end
            end else begin
                baud_cnt <= baud_cnt + CNT_W'(1);
            end
        end
    end

    // Registered outputs lag the FSM by one cycle, keeping the line glitch-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            uart_TX <= 1'b1;
            busy    <= 1'b0;
            tx_done <= 1'b0;
        end else begin
            uart_TX <= tx_bit_c;
            busy    <= (state != IDLE) || (state_next_c != IDLE);
            tx_done <= done_c;
        end
    end

endmodule

// File: doc/gpio_uart_tx.md
Name: gpio_uart_tx

Overview:
- 8N1 UART transmitter with a small write FIFO.
- Generates the serial `uart_TX` line consumed by the GPIO pad mux when a pin's function select = 2 (UART TX).
- The CPU/bus side pushes bytes; the block serialises them LSB-first at a fixed baud set by a clock divider.
- Line idles high, so a pin switched to UART function sees a valid idle level.

Parameters:
- CLK_DIV, 868, clk cycles per UART bit (≥2; 868 = 115200 baud at 100 MHz).
- FIFO_DEPTH, 4, byte entries in TX FIFO (power of 2, ≥2).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- wr_en  input  1  push wr_data into FIFO this cycle.
- wr_data  input  8  byte to transmit.
- full  output  1  FIFO holds FIFO_DEPTH entries.
- empty  output  1  FIFO holds 0 entries.
- overflow  output  1  sticky: a write was attempted while full.
- busy  output  1  FSM not in IDLE (frame in progress).
- tx_done  output  1  one-cycle pulse at the end of each stop bit.
- uart_TX  output  1  serial line to GPIO mux, registered, idle high.

Behaviour:
- Reset (rst=1 at a clk edge):
  - FIFO pointers and count = 0, so empty=1 and full=0.
  - overflow=0, busy=0, tx_done=0, uart_TX=1.
  - FSM returns to IDLE; baud counter and bit index = 0.
  - Reset mid-frame aborts the frame: uart_TX is 1 the cycle after reset and the line does not resume the old frame.
- FIFO:
  - Write accepted when wr_en=1 and full=0, i.e. full as registered before any same-cycle pop.
  - A write while full is dropped and sets overflow=1; overflow is cleared only by rst.
  - A simultaneous accepted write and pop leaves the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - full and empty are registered and derived from the count.
- FSM states:
  - IDLE: uart_TX=1.
    - If empty=0: pop the head into the shift register, go to START, clear the baud counter.
  - START: uart_TX=0 for CLK_DIV cycles, then go to DATA with bit index 0.
  - DATA: uart_TX=shift[0] for CLK_DIV cycles, then shift right and increment the bit index.
    - After bit 7 completes, go to STOP.
  - STOP: uart_TX=1 for CLK_DIV cycles.
    - At the last cycle, pulse tx_done=1.
    - If empty=0: pop and go straight to START (zero idle gap between frames).
    - Otherwise go to IDLE.
- Baud counter:
  - Counts 0..CLK_DIV-1 and wraps to 0 at each bit boundary.
  - Width is clog2(CLK_DIV).
- Frame timing:
  - Exactly 10*CLK_DIV cycles from the first start-bit cycle to the last stop-bit cycle.
- Latency:
  - wr_en sampled at edge k with FSM in IDLE and FIFO empty: empty falls after edge k, pop occurs at edge k+1, uart_TX goes low after edge k+2.
- busy:
  - 1 from the pop cycle through the last STOP cycle; 0 in IDLE.
  - Stays 1 across back-to-back frames.
- Outputs:
  - uart_TX is driven from a flop (no combinational path from wr_en).
- Pad behaviour:
  - The block has no knowledge of the pad function select.
  - uart_TX toggles regardless of whether the mux routes it to a pin.

Test Plan:
- Reset check: CLK_DIV=4. Hold rst=1 for 3 cycles -> uart_TX=1, empty=1, full=0, busy=0, overflow=0, tx_done=0.
- Single byte: write 0xA5 once.
  - uart_TX low 2 cycles after the write edge.
  - Then per 4-cycle bit: 0(start), 1,0,1,0,0,1,0,1, 1(stop).
  - tx_done pulses once at cycle 40 of the frame; busy falls the next cycle.
- Back-to-back: write 0x00, 0xFF on consecutive cycles -> two frames with no idle-high cycle between stop(0x00) and start(0xFF); tx_done pulses twice, 40 cycles apart.
- Overflow: with FSM transmitting, write 5 bytes while FIFO_DEPTH=4 and no pop occurs.
  - full=1 after the 4th accepted write; the 5th write is dropped and overflow=1.
  - Transmitted sequence equals the first bytes only.
- Full plus pop same cycle: FIFO full, and wr_en=1 on the cycle STOP pops -> write dropped, overflow=1, count=3 after the edge.
- Reset mid-frame: assert rst during DATA bit 3 of 0x55 -> uart_TX=1 and busy=0 the next cycle, FIFO empty, no tx_done pulse.
  - A fresh write after reset transmits a complete correct frame.
